// File: rtl/sprite_pkg.sv
// Shared types for the per-line sprite evaluator: table entry, draw-unit slot, draw height.
package sprite_pkg;
  localparam int CORDW    = 16;
  localparam int IDXW_MAX = 9;  // enough for 512 table entries
  localparam int ROWW_MAX = 8;

  typedef struct packed {
    logic             en;
    logic [CORDW-1:0] x;
    logic [CORDW-1:0] y;
  } spr_entry_t;

  typedef struct packed {
    logic                valid;
    logic [IDXW_MAX-1:0] idx;
    logic [CORDW-1:0]    x;
    logic [ROWW_MAX-1:0] row;
  } unit_slot_t;

  function automatic int drawh(input int height, input int scale);
    return height << scale;
  endfunction
endpackage

// File: rtl/sprite_hit.sv
// Signed vertical range test of one sprite against the target line, plus its bitmap row.
module sprite_hit #(
  parameter int CORDW     = 16,
  parameter int DRAWH     = 64,
  parameter int SPR_SCALE = 3,
  parameter int ROWW      = 3
) (
  input  logic                    en,
  input  logic signed [CORDW-1:0] spr_y,
  input  logic signed [CORDW:0]   target,
  output logic                    hit,
  output logic [ROWW-1:0]         row
);
  localparam logic signed [CORDW:0] DRAWH_S = (CORDW+1)'(DRAWH);
  localparam int DW = SPR_SCALE + ROWW;

  logic signed [CORDW:0] y_ext;
  logic signed [CORDW:0] y_end;
  logic [DW-1:0]         diff_lo;

  assign y_ext   = {spr_y[CORDW-1], spr_y};
  assign y_end   = y_ext + DRAWH_S;
  assign hit     = en && (y_ext <= target) && (target < y_end);
  // Only the low bits of the offset matter once the row is truncated.
  assign diff_lo = target[DW-1:0] - y_ext[DW-1:0];
  assign row     = ROWW'(diff_lo >> SPR_SCALE);
endmodule

// File: rtl/sprite_eval.sv
// Scans the sprite table once per line and assigns up to NUNIT hits to draw units,
// committing each line's result on the following line pulse.
module sprite_eval #(
  parameter int CORDW      = 16,
  parameter int NSPR       = 16,
  parameter int NUNIT      = 4,
  parameter int SPR_HEIGHT = 8,
  parameter int SPR_SCALE  = 3
) (
  input  logic                                clk_pix,
  input  logic                                rst_pix,
  input  logic                                line,
  input  logic signed [CORDW-1:0]             sy,
  input  logic                                tbl_we,
  input  logic [$clog2(NSPR)-1:0]             tbl_addr,
  input  logic                                tbl_en,
  input  logic signed [CORDW-1:0]             tbl_x,
  input  logic signed [CORDW-1:0]             tbl_y,
  output logic [NUNIT-1:0]                    unit_valid,
  output logic [NUNIT*$clog2(NSPR)-1:0]       unit_idx,
  output logic [NUNIT*CORDW-1:0]              unit_x,
  output logic [NUNIT*$clog2(SPR_HEIGHT)-1:0] unit_row,
  output logic                                overflow,
  output logic                                eval_busy,
  output logic                                eval_late
);
  import sprite_pkg::*;

  localparam int IW = $clog2(NSPR);
  localparam int RW = $clog2(SPR_HEIGHT);
  localparam int DH = drawh(SPR_HEIGHT, SPR_SCALE);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic signed [CORDW:0] target_q, target_d;
  spr_entry_t            tbl_q [NSPR];
  spr_entry_t            tbl_d [NSPR];
  unit_slot_t            shadow_q [NUNIT];
  unit_slot_t            shadow_d [NUNIT];
  unit_slot_t            out_q [NUNIT];
  unit_slot_t            out_d [NUNIT];
  logic                  sovf_q, sovf_d;
  logic                  oovf_q, oovf_d;
  logic                  late_q, late_d;

  spr_entry_t    cur;
  unit_slot_t    new_slot;
  logic          hit;
  logic [RW-1:0] hit_row;
  logic          placed;

  assign cur = tbl_q[idx_q];

  sprite_hit #(
    .CORDW    (CORDW),
    .DRAWH    (DH),
    .SPR_SCALE(SPR_SCALE),
    .ROWW     (RW)
  ) u_hit (
    .en    (cur.en),
    .spr_y ($signed(cur.y)),
    .target(target_q),
    .hit   (hit),
    .row   (hit_row)
  );

  always_comb begin
    new_slot.valid = 1'b1;
    new_slot.idx   = IDXW_MAX'(idx_q);
    new_slot.x     = cur.x;
    new_slot.row   = ROWW_MAX'(hit_row);
  end

  always_comb begin
    tbl_d    = tbl_q;
    state_d  = state_q;
    idx_d    = idx_q;
    target_d = target_q;
    shadow_d = shadow_q;
    sovf_d   = sovf_q;
    out_d    = out_q;
    oovf_d   = oovf_q;
    late_d   = late_q;
    placed   = 1'b0;

    if (tbl_we) tbl_d[tbl_addr] = '{en: tbl_en, x: tbl_x, y: tbl_y};

    // A line pulse always wins: commit whatever the shadow holds and restart.
    if (line) begin
      out_d    = shadow_q;
      oovf_d   = sovf_q;
      for (int k = 0; k < NUNIT; k++) shadow_d[k] = '0;
      sovf_d   = 1'b0;
      target_d = {sy[CORDW-1], sy} + (CORDW+1)'(1);
      idx_d    = '0;
      state_d  = SCAN;
      if (state_q == SCAN) late_d = 1'b1;
    end else if (state_q == SCAN) begin
      if (hit) begin
        for (int k = 0; k < NUNIT; k++) begin
          if (!placed && !shadow_q[k].valid) begin
            shadow_d[k] = new_slot;
            placed      = 1'b1;
          end
        end
        if (!placed) sovf_d = 1'b1;
      end
      if (idx_q == IW'(NSPR-1)) state_d = IDLE;
      else                      idx_d   = idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      target_q <= '0;
      sovf_q   <= 1'b0;
      oovf_q   <= 1'b0;
      late_q   <= 1'b0;
      for (int i = 0; i < NSPR; i++) tbl_q[i] <= '0;
      for (int k = 0; k < NUNIT; k++) begin
        shadow_q[k] <= '0;
        out_q[k]    <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      target_q <= target_d;
      sovf_q   <= sovf_d;
      oovf_q   <= oovf_d;
      late_q   <= late_d;
      tbl_q    <= tbl_d;
      shadow_q <= shadow_d;
      out_q    <= out_d;
    end
  end

  for (genvar k = 0; k < NUNIT; k++) begin : g_out
    assign unit_valid[k]          = out_q[k].valid;
    assign unit_idx[k*IW +: IW]   = IW'(out_q[k].idx);
    assign unit_x[k*CORDW +: CORDW] = CORDW'(out_q[k].x);
    assign unit_row[k*RW +: RW]   = RW'(out_q[k].row);
  end

  assign overflow  = oovf_q;
  assign eval_busy = (state_q == SCAN);
  assign eval_late = late_q;
endmodule

// File: doc/sprite_eval.md
# sprite_eval

Per-line sprite evaluation scheduler for the pixel-clock domain. Holds a table of `NSPR` sprite positions and, once per scanline, scans the table to pick up to `NUNIT` sprites that intersect the next line. It assigns those sprites to the hardware sprite draw units and reports the bitmap row each unit must fetch. It sits between game/CPU-side position updates and the bank of `sprite` draw units fed by `display_480p`.

## Interface
Parameters:
- `CORDW`, 16: signed coordinate width.
- `NSPR`, 16: sprite table entries, 2..512.
- `NUNIT`, 4: hardware draw units, 1..8.
- `SPR_HEIGHT`, 8: bitmap height in rows, power of two.
- `SPR_SCALE`, 3: vertical scale exponent; draw height `DRAWH = SPR_HEIGHT << SPR_SCALE`.

Ports:
- `clk_pix` in 1: pixel clock. The block uses one clock.
- `rst_pix` in 1: reset, synchronous, active-high.
- `line` in 1: one-cycle pulse at the start of each line, from `display_480p`.
- `sy` in CORDW (signed): current line; valid when `line` is high.
- `tbl_we` in 1: table write strobe.
- `tbl_addr` in $clog2(NSPR): entry to write.
- `tbl_en` in 1: entry enable.
- `tbl_x`, `tbl_y` in CORDW (signed): sprite position.
- `unit_valid` out NUNIT: unit k has a sprite on the current line.
- `unit_idx` out NUNIT*$clog2(NSPR): table index per unit.
- `unit_x` out NUNIT*CORDW: x position per unit.
- `unit_row` out NUNIT*$clog2(SPR_HEIGHT): bitmap row per unit.
- `overflow` out 1: more than NUNIT hits on the current line.
- `eval_busy` out 1: scan in progress.
- `eval_late` out 1: sticky; a `line` pulse arrived mid-scan.

## Operation
- The FSM has two states, IDLE and SCAN. IDLE goes to SCAN on `line`. SCAN goes to IDLE after entry NSPR-1 has been examined.
- On a `line` pulse, in every state:
  - Copy the shadow set (unit fields plus overflow) to the outputs.
  - Clear the shadow set.
  - Latch `target = sy + 1`.
  - Set the scan index to 0 and enter SCAN.
- In SCAN, examine one entry per cycle in ascending index order.
  - Hit condition: `en && tbl_y <= target && target < tbl_y + DRAWH`. The compare is signed, at CORDW+1 bits, with no overflow wrap.
  - A hit fills the lowest free shadow unit with: idx, x, and `row = (target - tbl_y) >> SPR_SCALE`.
  - A hit that finds all units full sets shadow overflow and is dropped, so lower indices have priority.
- A `line` pulse that arrives during SCAN is not an error:
  - The partial shadow is committed as-is.
  - `eval_late` is set and stays set until reset.
  - The scan restarts for the new target.
- Table writes:
  - A write takes effect at the clock edge.
  - If the scan examines the same entry in the same cycle as its write, the scan uses the old value.
  - Writes are allowed in any state.
- The line after the vertical wrap is evaluated against the previous `sy + 1`; it falls inside blanking and is accepted.
- Unused units output `unit_valid = 0` and zeros in their other fields.

## Timing
- `line` pulse at cycle t:
  - Outputs update at t+1.
  - `eval_busy` is high from t+1 through t+NSPR.
  - Entry i is examined in cycle t+1+i.
  - Results appear on the outputs at the next `line` pulse plus 1 cycle.
- Output-to-line latency: a sprite is reported on the outputs one line after its evaluation, which is exactly the line it intersects.
- Outputs change only in the cycle after `line`, or on reset.
- Values after reset:
  - All outputs 0.
  - All table `en` bits 0.
  - FSM in IDLE; shadow cleared.

## Structure
- Package `sprite_pkg` holds:
  - `CORDW`.
  - The sprite entry typedef {en, x, y}.
  - The unit slot typedef {valid, idx, x, row}.
  - The `DRAWH` function.
- Sub-module `sprite_hit`: combinational signed range compare plus row calculation, instantiated once in the scan path.
- The table is a register array, not RAM, so the scan can read and the write port can write in the same cycle.

## Test plan
All scenarios use defaults: NSPR=16, NUNIT=4, DRAWH=64.
- **Single sprite:** entry 3 = {1, x=100, y=200}; `line` with sy=199. Next `line` (sy=200) gives unit0 = {1, 3, 100, row 0}. sy=263 gives row 7. sy=264 gives unit_valid=0.
- **Overflow:** entries 0..5 enabled at y=50; target 60. Units hold idx 0..3, `overflow`=1. Entries 4 and 5 are absent.
- **Negative y:** entry 0 at y=-10; target 20. Row = 30>>3 = 3. A disabled entry in range is never assigned.
- **Write collision:** write entry 5 in cycle t+6 (when it is scanned). The old value is used. On the following line the new value is used.
- **Late line:** `line` pulses 5 cycles apart. `eval_late`=1, and the committed set contains only entries 0..3 that hit.
- **Reset mid-scan:** assert `rst_pix` at t+8. The next cycle has all outputs 0, table disabled, FSM in IDLE, and no scan until the next `line`.
